bram_initiator: RTL and testbench

BRAM_INITIATOR -- requirements
Module: bram_initiator

---
 rtl/bram_initiator.sv | 106 ++++++++++
 tb/tb_bram_initiator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_initiator.sv
// bram_initiator: request/response front end driving a single-port block RAM with one outstanding read.
// Define BRAM_INITIATOR_CLEAR_EN to zero the whole RAM after every reset (CLEAR state, busy high).
module bram_initiator #(
  parameter int DATA_W = 33,
  parameter int ADDR_W = 33,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);
  typedef enum logic [1:0] {
`ifdef BRAM_INITIATOR_CLEAR_EN
    CLEAR,
`endif
    IDLE,
    RD_WAIT,
    RSP
  } state_t;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
`ifdef BRAM_INITIATOR_CLEAR_EN
  localparam state_t RST_ST = CLEAR;
`else
  localparam state_t RST_ST = IDLE;
`endif
  state_t state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] di_q;
  logic accept, in_range, acc_ok, clr, last;
  // accept is masked by rst so no RAM access can leak out while reset is held
  assign accept   = req_valid & req_ready & ~rst;
  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign acc_ok   = accept & in_range;
`ifdef BRAM_INITIATOR_CLEAR_EN
  logic [ADDR_W-1:0] cnt;
  assign clr  = (state == CLEAR) & ~rst;
  assign last = cnt == ADDR_W'(DEPTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= cnt + 1'b1;
`else
  assign clr  = 1'b0;
  assign last = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RST_ST;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
`ifdef BRAM_INITIATOR_CLEAR_EN
      CLEAR:   nxt = last ? IDLE : CLEAR;
`endif
      IDLE:    nxt = (accept & ~req_we) ? (in_range ? RD_WAIT : RSP) : IDLE;
      RD_WAIT: nxt = RSP;
      RSP:     nxt = rsp_ready ? IDLE : RSP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RSP;
    busy      = clr;
    ram_en    = acc_ok | clr;
    ram_we    = (acc_ok & req_we) | clr;
`ifdef BRAM_INITIATOR_CLEAR_EN
    ram_addr  = clr ? cnt : acc_ok ? req_addr : addr_q;
`else
    ram_addr  = acc_ok ? req_addr : addr_q;
`endif
    ram_di    = clr ? '0 : acc_ok ? req_wdata : di_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q    <= '0;
      di_q      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (ram_en) begin
        addr_q <= ram_addr;
        di_q   <= ram_di;
      end
      if (state == RD_WAIT) begin
        rsp_rdata <= ram_dout;
        rsp_err   <= 1'b0;
      end else if (state == IDLE && accept && !req_we && !in_range) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_bram_initiator.sv
// tb_bram_initiator: directed self-checking bench for bram_initiator with a behavioural 1-cycle-latency RAM.
module tb_bram_initiator;
  localparam int DW = 33, AW = 33, DEPTH = 1024;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, ram_en, ram_we, busy;
  logic [DW-1:0] rsp_rdata, ram_di, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [DEPTH];
  int checks = 0, failures = 0;
  bram_initiator #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 33'h1_5555_AAAA;
    ram_dout = '0;
  end
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr[9:0]] <= ram_di;
      ram_dout <= mem[ram_addr[9:0]];
    end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: valid=%b rdata=%h err=%b required 0/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_di !== '0) begin
      failures++;
      $display("FAIL reset_ram: en=%b we=%b addr=%h di=%h required all 0", ram_en, ram_we, ram_addr, ram_di);
    end
    step();
    rst = 1'b0;
    #1;
`ifdef BRAM_INITIATOR_CLEAR_EN
    begin
      int n = 0;
      while (busy === 1'b1 && n < 2000) begin
        if (req_ready !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_di !== '0 || ram_addr !== AW'(n)) begin
          failures++;
          $display("FAIL clear_cycle: n=%0d ready=%b en=%b we=%b addr=%h di=%h", n, req_ready, ram_en, ram_we, ram_addr, ram_di);
        end
        n++;
        step();
      end
      checks++;
      if (n != DEPTH) begin
        failures++;
        $display("FAIL clear_len: busy cycles %0d required %0d", n, DEPTH);
      end
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_done: ready=%b busy=%b required 1/0", req_ready, busy);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 33'd1023;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL clear_readback: valid=%b rdata=%h err=%b required 1/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`else
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_reset: ready=%b busy=%b required 1/0", req_ready, busy);
    end
`endif
  endtask
  task automatic test_write_read;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 33'd5; req_wdata = 33'h1_2345_6789;
    #1;
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 33'd5 || ram_di !== 33'h1_2345_6789) begin
      failures++;
      $display("FAIL wr_drive: en=%b we=%b addr=%h di=%h required 1/1/5/123456789", ram_en, ram_we, ram_addr, ram_di);
    end
    step();
    req_valid = 1'b0;
    #1;
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 33'd5 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_after: en=%b we=%b addr=%h ready=%b rvalid=%b required 0/0/5/1/0", ram_en, ram_we, ram_addr, req_ready, rsp_valid);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 33'd5; req_wdata = '0;
    #1;
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 33'd5) begin
      failures++;
      $display("FAIL rd_drive: en=%b we=%b addr=%h required 1/0/5", ram_en, ram_we, ram_addr);
    end
    step();
    req_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || ram_en !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rd_wait: rvalid=%b en=%b ready=%b required 0/0/0", rsp_valid, ram_en, req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 33'h1_2345_6789 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rd_rsp: valid=%b rdata=%h err=%b required 1/123456789/0", rsp_valid, rsp_rdata, rsp_err);
    end
  endtask
  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 33'h1_2345_6789 || req_ready !== 1'b0 || ram_en !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b rdata=%h ready=%b en=%b required 1/123456789/0/0", i, rsp_valid, rsp_rdata, req_ready, ram_en);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL release: valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask
  task automatic test_out_of_range;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 33'd1024;
    #1;
    checks++;
    if (ram_en !== 1'b0) begin
      failures++;
      $display("FAIL oor_rd_en: en=%b required 0", ram_en);
    end
    step();
    req_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== '0 || rsp_err !== 1'b1 || ram_en !== 1'b0) begin
      failures++;
      $display("FAIL oor_rd_rsp: valid=%b rdata=%h err=%b en=%b required 1/0/1/0", rsp_valid, rsp_rdata, rsp_err, ram_en);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 33'd2000; req_wdata = 33'h0_DEAD_BEEF;
    #1;
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 33'd5) begin
      failures++;
      $display("FAIL oor_wr: en=%b we=%b addr=%h required 0/0/5", ram_en, ram_we, ram_addr);
    end
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL oor_wr_rsp: valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask
  task automatic test_back_to_back;
    int hits = 0;
    req_valid = 1'b1; req_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'(i);
      req_wdata = DW'(i * 3 + 7);
      #1;
      if (ram_en === 1'b1 && ram_we === 1'b1 && req_ready === 1'b1 && ram_addr === AW'(i) && ram_di === DW'(i * 3 + 7)) hits++;
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (hits != 8) begin
      failures++;
      $display("FAIL b2b_writes: good cycles %0d required 8", hits);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 33'd6;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 33'd25 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_readback: valid=%b rdata=%h err=%b required 1/19/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset_in_rsp;
    logic [DW-1:0] exp;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 33'd5;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: rsp_valid=%b required 1", rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || ram_en !== 1'b0 || ram_addr !== '0) begin
      failures++;
      $display("FAIL rst_async: valid=%b rdata=%h err=%b en=%b addr=%h required 0/0/0/0/0", rsp_valid, rsp_rdata, rsp_err, ram_en, ram_addr);
    end
    step();
    rst = 1'b0;
`ifdef BRAM_INITIATOR_CLEAR_EN
    exp = '0;
    for (int n = 0; n < 2000 && busy === 1'b1; n++) step();
`else
    exp = 33'd16;
`endif
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 33'd3;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_recover: valid=%b rdata=%h err=%b required 1/%h/0", rsp_valid, rsp_rdata, rsp_err, exp);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_rsp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
